// File: rtl/tv80_bus_model_if.sv
// CPU-side bus of the tv80s core as seen by the memory/I/O responder.
// Handshake: the CPU opens an access by pulling mreq_n or iorq_n low; while the
// responder holds wait_n low the CPU must keep its strobes, address and data
// stable; the access ends when mreq_n and iorq_n are both high again.
interface tv80_bus_model_if;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic [7:0]  di;
    logic        wait_n;

    modport master (
        output A, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        input  di, wait_n
    );

    modport slave (
        input  A, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        output di, wait_n
    );
endinterface

// File: rtl/tv80_bus_model.sv
// Memory + I/O responder for tv80s benches: wait-state insertion, write log
// FIFO, opcode-fetch counter and a backdoor memory preload port.
module tv80_bus_model #(
    parameter int ADDR_W    = 16,
    parameter int IO_ADDR_W = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 0,
    parameter int LOG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    tv80_bus_model_if.slave   bus,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_data,
    output logic              log_valid,
    output logic [15:0]       log_addr,
    output logic [7:0]        log_data,
    output logic              log_is_io,
    input  logic              log_pop,
    output logic              log_ovf,
    output logic [31:0]       m1_count,
    output logic [1:0]        dbg_state
);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
    localparam logic [3:0] IO_N  = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [3:0]  start_n;

    logic [7:0]  mem [2**ADDR_W];
    logic [7:0]  io  [2**IO_ADDR_W];
    logic [24:0] log_mem [LOG_DEPTH];

    logic [PW:0] wr_ptr, rd_ptr;
    logic        prev_idle;
    logic        wr_done;

    logic        req_idle, access_start, is_io_access, int_ack, commit;
    logic        log_empty, log_full, do_pop, do_push, do_drop;
    logic [24:0] log_head;
    logic [ADDR_W-1:0]    mem_addr;
    logic [IO_ADDR_W-1:0] io_addr;
    logic        unused_rd;

    // The read strobe is implied by the request lines; di is driven every cycle.
    assign unused_rd = bus.rd_n;

    assign req_idle     = bus.mreq_n & bus.iorq_n;
    assign access_start = prev_idle & ~req_idle & bus.rfsh_n;
    assign is_io_access = ~bus.iorq_n;
    assign int_ack      = ~bus.m1_n & ~bus.iorq_n;
    assign commit       = ~bus.wr_n & ~req_idle & ~wr_done & ~int_ack;
    assign start_n      = is_io_access ? IO_N : MEM_N;
    assign mem_addr     = bus.A[ADDR_W-1:0];
    assign io_addr      = bus.A[IO_ADDR_W-1:0];

    assign log_empty = (wr_ptr == rd_ptr);
    assign log_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop    = log_pop & ~log_empty;
    // A pop in the same cycle frees the slot, so a full log still accepts the push.
    assign do_push   = commit & (~log_full | do_pop);
    assign do_drop   = commit & log_full & ~do_pop;

    assign log_head  = log_mem[rd_ptr[PW-1:0]];
    assign log_valid = ~log_empty;
    assign log_addr  = log_empty ? 16'h0000 : log_head[24:9];
    assign log_data  = log_empty ? 8'h00 : log_head[8:1];
    assign log_is_io = log_empty ? 1'b0 : log_head[0];
    assign dbg_state = state;

    // Wait FSM next-state and wait_n decode.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        bus.wait_n   = 1'b1;
        case (state)
            S_IDLE: begin
                if (access_start) begin
                    if (start_n != 4'd0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = start_n;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                bus.wait_n = 1'b0;
                if (wait_cnt == 4'd1) state_nxt = S_HOLD;
                else wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_HOLD: begin
                if (req_idle) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, access tracking, log pointers, overflow flag, M1 counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            prev_idle <= 1'b0;
            wr_done   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_ovf   <= 1'b0;
            m1_count  <= 32'd0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            prev_idle <= req_idle;
            if (req_idle) wr_done <= 1'b0;
            else if (commit) wr_done <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_drop) log_ovf <= 1'b1;
            if (access_start && !bus.m1_n && !bus.mreq_n && m1_count != 32'hFFFF_FFFF)
                m1_count <= m1_count + 32'd1;
        end
    end

    // Log storage; entries are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (do_push) log_mem[wr_ptr[PW-1:0]] <= {bus.A, bus.dout, is_io_access};
    end

    // Array writes: the CPU write is last so it overrides a colliding backdoor write.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (commit && !is_io_access) mem[mem_addr] <= bus.dout;
        if (commit && is_io_access) io[io_addr] <= bus.dout;
    end

    // Read data is launched on the falling edge so it is settled by the CPU's sample edge.
    always_ff @(negedge clk) begin
        if (reset) bus.di <= 8'h00;
        else if (!bus.iorq_n) bus.di <= io[io_addr];
        else bus.di <= mem[mem_addr];
    end
endmodule

// File: tb/tb_tv80_bus_model.sv
// Bench for tv80_bus_model: dut_a (MEM_WAIT=2, IO_WAIT=1, LOG_DEPTH=4) carries most
// checks, dut_b (MEM_WAIT=5) covers reset in the middle of a wait sequence.
module tb_tv80_bus_model;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b;

    logic [15:0] A;
    logic [7:0]  dout;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;
    logic        pop_a, pop_b;

    logic        log_valid_a, log_is_io_a, log_ovf_a;
    logic [15:0] log_addr_a;
    logic [7:0]  log_data_a;
    logic [31:0] m1_count_a;
    logic [1:0]  dbg_state_a;
    logic        log_valid_b, log_is_io_b, log_ovf_b;
    logic [15:0] log_addr_b;
    logic [7:0]  log_data_b;
    logic [31:0] m1_count_b;
    logic [1:0]  dbg_state_b;

    tv80_bus_model_if bus_a ();
    tv80_bus_model_if bus_b ();

    assign bus_a.A = A;       assign bus_b.A = A;
    assign bus_a.dout = dout; assign bus_b.dout = dout;
    assign bus_a.mreq_n = mreq_n; assign bus_b.mreq_n = mreq_n;
    assign bus_a.iorq_n = iorq_n; assign bus_b.iorq_n = iorq_n;
    assign bus_a.rd_n = rd_n;     assign bus_b.rd_n = rd_n;
    assign bus_a.wr_n = wr_n;     assign bus_b.wr_n = wr_n;
    assign bus_a.m1_n = m1_n;     assign bus_b.m1_n = m1_n;
    assign bus_a.rfsh_n = rfsh_n; assign bus_b.rfsh_n = rfsh_n;

    tv80_bus_model #(.ADDR_W(16), .IO_ADDR_W(8), .MEM_WAIT(2), .IO_WAIT(1), .LOG_DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
        .log_valid(log_valid_a), .log_addr(log_addr_a), .log_data(log_data_a),
        .log_is_io(log_is_io_a), .log_pop(pop_a), .log_ovf(log_ovf_a),
        .m1_count(m1_count_a), .dbg_state(dbg_state_a)
    );

    tv80_bus_model #(.ADDR_W(16), .IO_ADDR_W(8), .MEM_WAIT(5), .IO_WAIT(0), .LOG_DEPTH(16)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
        .log_valid(log_valid_b), .log_addr(log_addr_b), .log_data(log_data_b),
        .log_is_io(log_is_io_b), .log_pop(pop_b), .log_ovf(log_ovf_b),
        .m1_count(m1_count_b), .dbg_state(dbg_state_b)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [24:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic wait_sel(input int sel);
        return (sel == 1) ? bus_b.wait_n : bus_a.wait_n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_release();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic bd_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk); #1;
        bd_we = 1'b1; bd_addr = addr; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // One CPU bus cycle; returns the read data and the number of sampled wait_n=0 cycles.
    task automatic do_access(input int sel, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic is_io, input logic is_wr, input logic is_m1,
                             input logic with_bd, input logic [7:0] bd_d, input logic pop_now,
                             output logic [7:0] rdata, output int waits);
        logic done;
        @(negedge clk); #1;
        A = addr; dout = wdata; m1_n = ~is_m1;
        if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
        if (with_bd) begin bd_we = 1'b1; bd_addr = addr; bd_data = bd_d; end
        if (pop_now) pop_a = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            bd_we = 1'b0; pop_a = 1'b0;
            if (wait_sel(sel) === 1'b0) waits++;
            else done = 1'b1;
        end
        check("wait_release", {31'd0, done}, 32'd1);
        @(negedge clk); #1;
        rdata = (sel == 1) ? bus_b.di : bus_a.di;
        bus_release();
    endtask

    task automatic refresh_cycle();
        @(negedge clk); #1;
        A = 16'h0040; mreq_n = 1'b0; rfsh_n = 1'b0;
        @(posedge clk); #1;
        check("rfsh_wait_n", {31'd0, bus_a.wait_n}, 32'd1);
        check("rfsh_state", {30'd0, dbg_state_a}, 32'd0);
        @(negedge clk); #1;
        bus_release();
    endtask

    task automatic pop_check(input string name);
        logic [24:0] e;
        e = exp_q.pop_front();
        check({name, "_valid"}, {31'd0, log_valid_a}, 32'd1);
        check(name, {7'd0, log_addr_a, log_data_a, log_is_io_a}, {7'd0, e});
        pop_a = 1'b1;
        @(posedge clk); #1;
        pop_a = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        is_io;
        int          exp_waits;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  rd;
    int          w;
    logic [15:0] ix, ea;
    logic [7:0]  disp, op, old_v, new_v;

    initial begin
        vecs[0] = '{16'h4000, 8'h3C, 1'b0, 2};
        vecs[1] = '{16'hFFFF, 8'hFF, 1'b0, 2};
        vecs[2] = '{16'h0042, 8'h00, 1'b1, 1};
        vecs[3] = '{16'h7E80, 8'h81, 1'b1, 1};
        vecs[4] = '{16'h8000, 8'h5A, 1'b0, 2};
        vecs[5] = '{16'hAB00, 8'hC3, 1'b1, 1};

        A = 16'h0000; dout = 8'h00; bus_release();
        bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 8'h00;
        pop_a = 1'b0; pop_b = 1'b0;

        // reset
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        check("rst_wait_n", {31'd0, bus_a.wait_n}, 32'd1);
        check("rst_log_valid", {31'd0, log_valid_a}, 32'd0);
        check("rst_log_ovf", {31'd0, log_ovf_a}, 32'd0);
        check("rst_m1_count", m1_count_a, 32'd0);
        check("rst_di", {24'd0, bus_a.di}, 32'd0);
        check("rst_log_addr", {16'd0, log_addr_a}, 32'd0);
        check("rst_state", {30'd0, dbg_state_a}, 32'd0);

        // preloaded read with two wait states
        bd_write(16'h1234, 8'hA5);
        do_access(0, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("rd1234_waits", w, 32'd2);
        check("rd1234_di", {24'd0, rd}, 32'h0000_00A5);
        check("bd_not_logged", {31'd0, log_valid_a}, 32'd0);

        // backdoor and CPU write to the same address in the same cycle
        do_access(0, 16'h0300, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, rd, w);
        exp_q.push_back({16'h0300, 8'h22, 1'b0});
        pop_check("log_collide");
        do_access(0, 16'h0300, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("collide_cpu_wins", {24'd0, rd}, 32'h0000_0022);

        // DD CB 62 8B : RES 1,(IX+62h) with IX=1685h
        bd_write(16'h0000, 8'hDD);
        bd_write(16'h0001, 8'hCB);
        bd_write(16'h0002, 8'h62);
        bd_write(16'h0003, 8'h8B);
        bd_write(16'h16E7, 8'h8A);
        ix = 16'h1685;
        do_access(0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, rd, w);
        check("fetch_dd", {24'd0, rd}, 32'h0000_00DD);
        refresh_cycle();
        do_access(0, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, rd, w);
        check("fetch_cb", {24'd0, rd}, 32'h0000_00CB);
        refresh_cycle();
        do_access(0, 16'h0002, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, disp, w);
        do_access(0, 16'h0003, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, op, w);
        ea = ix + {{8{disp[7]}}, disp};
        do_access(0, ea, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, old_v, w);
        new_v = old_v & ~(8'h01 << op[5:3]);
        do_access(0, ea, new_v, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        exp_q.push_back({16'h16E7, 8'h88, 1'b0});
        check("ddcb_m1_count", m1_count_a, 32'd2);
        pop_check("ddcb_log");
        check("ddcb_single_entry", {31'd0, log_valid_a}, 32'd0);
        do_access(0, 16'h16E7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("ddcb_mem", {24'd0, rd}, 32'h0000_0088);

        // OUT (10h),A with A=5Ah, then IN A,(10h) and an interrupt acknowledge
        do_access(0, 16'h5A10, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("out_waits", w, 32'd1);
        exp_q.push_back({16'h5A10, 8'h5A, 1'b1});
        pop_check("out_log");
        do_access(0, 16'h5A10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("in_data", {24'd0, rd}, 32'h0000_005A);
        check("in_not_logged", {31'd0, log_valid_a}, 32'd0);
        do_access(0, 16'h0010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, rd, w);
        check("intack_data", {24'd0, rd}, 32'h0000_005A);
        check("intack_m1_count", m1_count_a, 32'd2);
        check("intack_not_logged", {31'd0, log_valid_a}, 32'd0);

        // table: writes with wait/log checks, then read back
        for (int i = 0; i < 6; i++) begin
            do_access(0, vecs[i].addr, vecs[i].data, vecs[i].is_io, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
            check($sformatf("vec%0d_wr_waits", i), w, vecs[i].exp_waits);
            exp_q.push_back({vecs[i].addr, vecs[i].data, vecs[i].is_io});
            pop_check($sformatf("vec%0d_log", i));
        end
        for (int i = 0; i < 6; i++) begin
            do_access(0, vecs[i].addr, 8'h00, vecs[i].is_io, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
            check($sformatf("vec%0d_rd_waits", i), w, vecs[i].exp_waits);
            check($sformatf("vec%0d_rd_data", i), {24'd0, rd}, {24'd0, vecs[i].data});
        end

        // full log with a pop in the commit cycle: both accepted, no overflow
        for (int i = 0; i < 4; i++) begin
            do_access(0, 16'h5000 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
            exp_q.push_back({16'h5000 + 16'(i), 8'h10 + 8'(i), 1'b0});
        end
        check("full_head", {7'd0, log_addr_a, log_data_a, log_is_io_a}, {7'd0, exp_q[0]});
        do_access(0, 16'h5004, 8'h14, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, rd, w);
        void'(exp_q.pop_front());
        exp_q.push_back({16'h5004, 8'h14, 1'b0});
        check("pop_push_no_ovf", {31'd0, log_ovf_a}, 32'd0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("popfull%0d", i));

        // five writes without pops: fifth dropped from the log only
        for (int i = 0; i < 5; i++) begin
            do_access(0, 16'h6000 + 16'(i), 8'h20 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
            if (i < 4) exp_q.push_back({16'h6000 + 16'(i), 8'h20 + 8'(i), 1'b0});
        end
        check("ovf_set", {31'd0, log_ovf_a}, 32'd1);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_entry%0d", i));
        check("ovf_drained", {31'd0, log_valid_a}, 32'd0);
        do_access(0, 16'h6004, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("ovf_fifth_in_mem", {24'd0, rd}, 32'h0000_0024);

        // dut_b: reset asserted during the second of five wait cycles
        @(negedge clk); #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_b = 1'b0;
        do_access(1, 16'h7000, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rd, w);
        check("b_wr_waits", w, 32'd5);
        check("b_log_valid", {31'd0, log_valid_b}, 32'd1);
        @(negedge clk); #1;
        A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
        @(posedge clk); #1;
        check("b_wait1", {31'd0, bus_b.wait_n}, 32'd0);
        @(posedge clk); #1;
        check("b_wait2", {31'd0, bus_b.wait_n}, 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        check("b_rst_wait_n", {31'd0, bus_b.wait_n}, 32'd1);
        check("b_rst_log_valid", {31'd0, log_valid_b}, 32'd0);
        check("b_rst_state", {30'd0, dbg_state_b}, 32'd0);
        @(negedge clk); #1;
        rst_b = 1'b0;
        bus_release();
        repeat (2) @(posedge clk);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
